// File: rtl/si570_freq_sequencer.sv
// Walks the I2C front-end through the Si570 reprogramming op list:
// switch select, old-config readback, freeze, write, unfreeze, NewFreq.
module si570_freq_sequencer #(
  parameter logic [6:0] SWITCH_ADDR = 7'h70,
  parameter logic [6:0] SI570_ADDR  = 7'h55,
  parameter int         WAIT_LIMIT  = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  i_switch_chan,
  input  logic [47:0] i_new_cfg,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [3:0]  o_step,
  output logic [47:0] o_old_cfg,
  input  logic        fe_idle,
  input  logic [7:0]  fe_status,
  input  logic [31:0] fe_rx_data,
  output logic [6:0]  fe_dev_addr,
  output logic [1:0]  fe_reg_num_len,
  output logic [15:0] fe_reg_num,
  output logic [2:0]  fe_read_len,
  output logic        fe_read_strobe,
  output logic [31:0] fe_tx_data,
  output logic [2:0]  fe_write_len,
  output logic        fe_write_strobe
);
  localparam int WD_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_CHECK, S_DONE, S_FAULT
  } state_t;

  state_t           r_state;
  logic [7:0]       r_chan;
  logic [47:0]      r_cfg;
  logic [WD_W-1:0]  r_wd;

  logic [6:0]  w_dev;
  logic [1:0]  w_rnl;
  logic [15:0] w_reg;
  logic        w_rd;
  logic [2:0]  w_len;
  logic [31:0] w_data;
  logic        w_unused_ok;

  assign w_unused_ok = &{1'b0, fe_status[7:3], fe_status[0]};

  // Op table, indexed by the current step.
  always_comb begin
    w_dev  = SI570_ADDR;
    w_rnl  = 2'd1;
    w_reg  = 16'd0;
    w_rd   = 1'b0;
    w_len  = 3'd1;
    w_data = 32'h0;
    case (o_step)
      4'd0: begin w_dev = SWITCH_ADDR; w_rnl = 2'd0; w_data = {24'h0, r_chan}; end
      4'd1: begin w_reg = 16'd7;   w_rd = 1'b1; w_len = 3'd4; end
      4'd2: begin w_reg = 16'd11;  w_rd = 1'b1; w_len = 3'd2; end
      4'd3: begin w_reg = 16'd137; w_data = 32'h10; end
      4'd4: begin w_reg = 16'd7;   w_len = 3'd4; w_data = r_cfg[47:16]; end
      4'd5: begin w_reg = 16'd11;  w_len = 3'd2; w_data = {16'h0, r_cfg[15:0]}; end
      4'd6: begin w_reg = 16'd137; end
      4'd7: begin w_reg = 16'd135; w_data = 32'h40; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_chan          <= '0;
      r_cfg           <= '0;
      r_wd            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fault           <= 1'b0;
      fault_code      <= 2'd0;
      o_step          <= 4'd0;
      o_old_cfg       <= '0;
      fe_dev_addr     <= '0;
      fe_reg_num_len  <= '0;
      fe_reg_num      <= '0;
      fe_read_len     <= '0;
      fe_read_strobe  <= 1'b0;
      fe_tx_data      <= '0;
      fe_write_len    <= '0;
      fe_write_strobe <= 1'b0;
    end else begin
      fe_read_strobe  <= 1'b0;
      fe_write_strobe <= 1'b0;
      done            <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_chan     <= i_switch_chan;
          r_cfg      <= i_new_cfg;
          fault      <= 1'b0;
          fault_code <= 2'd0;
          o_step     <= 4'd0;
          busy       <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: if (fe_idle) begin
          fe_dev_addr     <= w_dev;
          fe_reg_num_len  <= w_rnl;
          fe_reg_num      <= w_reg;
          fe_read_len     <= w_rd ? w_len : 3'd0;
          fe_write_len    <= w_rd ? 3'd0 : w_len;
          fe_tx_data      <= w_rd ? 32'h0 : w_data;
          fe_read_strobe  <= w_rd;
          fe_write_strobe <= !w_rd;
          r_wd            <= '0;
          r_state         <= S_SETTLE;
        end
        // Front-end may not have dropped idle yet; skip one sample.
        S_SETTLE: r_state <= S_WAIT;
        S_WAIT: begin
          if (fe_idle) begin
            r_state <= S_CHECK;
          end else if (r_wd == WD_W'(WAIT_LIMIT - 1)) begin
            fault      <= 1'b1;
            fault_code <= 2'd3;
            busy       <= 1'b0;
            r_state    <= S_FAULT;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_CHECK: begin
          if (fe_status[1] || fe_status[2]) begin
            fault      <= 1'b1;
            fault_code <= fe_status[1] ? 2'd1 : 2'd2;
            busy       <= 1'b0;
            r_state    <= S_FAULT;
          end else begin
            if (o_step == 4'd1) o_old_cfg[47:16] <= fe_rx_data;
            if (o_step == 4'd2) o_old_cfg[15:0]  <= fe_rx_data[15:0];
            if (o_step == 4'd7) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              o_step  <= o_step + 4'd1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_si570_freq_sequencer.sv
// Directed bench: emulated I2C front-end, op scoreboard, fault/reset scenarios.
module tb_si570_freq_sequencer;
  typedef struct packed {
    logic [6:0]  dev;
    logic [1:0]  rnl;
    logic [15:0] rg;
    logic        rd;
    logic [2:0]  len;
    logic [31:0] data;
  } op_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  i_switch_chan = '0;
  logic [47:0] i_new_cfg = '0;
  logic        busy, done, fault;
  logic [1:0]  fault_code;
  logic [3:0]  o_step;
  logic [47:0] o_old_cfg;
  logic        fe_idle;
  logic [7:0]  fe_status;
  logic [31:0] fe_rx_data;
  logic [6:0]  fe_dev_addr;
  logic [1:0]  fe_reg_num_len;
  logic [15:0] fe_reg_num;
  logic [2:0]  fe_read_len, fe_write_len;
  logic        fe_read_strobe, fe_write_strobe;
  logic [31:0] fe_tx_data;

  si570_freq_sequencer #(.SWITCH_ADDR(7'h70), .SI570_ADDR(7'h55), .WAIT_LIMIT(50)) dut (
    .clk(clk), .resetn(resetn), .start(start), .i_switch_chan(i_switch_chan),
    .i_new_cfg(i_new_cfg), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .o_step(o_step), .o_old_cfg(o_old_cfg),
    .fe_idle(fe_idle), .fe_status(fe_status), .fe_rx_data(fe_rx_data),
    .fe_dev_addr(fe_dev_addr), .fe_reg_num_len(fe_reg_num_len),
    .fe_reg_num(fe_reg_num), .fe_read_len(fe_read_len),
    .fe_read_strobe(fe_read_strobe), .fe_tx_data(fe_tx_data),
    .fe_write_len(fe_write_len), .fe_write_strobe(fe_write_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int hang_op = -1, bus_op = -1, to_op = -1;
  logic [47:0] si_regs = 48'h01C2BC011EB8;

  // Front-end emulator: busy for a few cycles after each strobe.
  int em_op, em_cur, em_cnt;
  bit em_hang;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fe_idle <= 1'b1; fe_status <= 8'h01; fe_rx_data <= '0;
      em_op <= 0; em_cur <= 0; em_cnt <= 0; em_hang <= 1'b0;
    end else if (start && !busy) begin
      em_op <= 0;
    end else if (fe_read_strobe || fe_write_strobe) begin
      em_op <= em_op + 1; em_cur <= em_op; em_cnt <= 3;
      em_hang <= (em_op == hang_op);
      fe_idle <= 1'b0; fe_status <= 8'h00;
      if (fe_reg_num == 16'd7)  fe_rx_data <= si_regs[47:16];
      if (fe_reg_num == 16'd11) fe_rx_data <= {16'h0, si_regs[15:0]};
    end else if (em_hang) begin
      if (!busy) begin em_hang <= 1'b0; fe_idle <= 1'b1; fe_status <= 8'h01; end
    end else if (!fe_idle) begin
      if (em_cnt == 1) begin
        fe_idle   <= 1'b1;
        fe_status <= {5'b0, em_cur == to_op, em_cur == bus_op, 1'b1};
      end else em_cnt <= em_cnt - 1;
    end
  end

  // Monitor: records every strobe, counts done pulses and protocol violations.
  op_t obs_q[$];
  int  done_cnt = 0, mon_bad = 0;
  bit  prev_stb = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (fe_read_strobe || fe_write_strobe)
        obs_q.push_back('{fe_dev_addr, fe_reg_num_len, fe_reg_num, fe_read_strobe,
                          fe_read_strobe ? fe_read_len : fe_write_len,
                          fe_read_strobe ? 32'h0 : fe_tx_data});
      if (fe_read_strobe && fe_write_strobe) mon_bad++;
      if (prev_stb && (fe_read_strobe || fe_write_strobe)) mon_bad++;
      if ((fe_read_strobe || fe_write_strobe) && !busy) mon_bad++;
      if (done) done_cnt++;
    end
    prev_stb = fe_read_strobe || fe_write_strobe;
  end

  op_t exp_q[$];
  int  rd_ptr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input logic [7:0] ch, input logic [47:0] cfg);
    @(posedge clk); #1;
    i_switch_chan = ch; i_new_cfg = cfg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [7:0] ch, input logic [47:0] cfg);
    exp_q.push_back('{7'h70, 2'd0, 16'd0,   1'b0, 3'd1, {24'h0, ch}});
    exp_q.push_back('{7'h55, 2'd1, 16'd7,   1'b1, 3'd4, 32'h0});
    exp_q.push_back('{7'h55, 2'd1, 16'd11,  1'b1, 3'd2, 32'h0});
    exp_q.push_back('{7'h55, 2'd1, 16'd137, 1'b0, 3'd1, 32'h10});
    exp_q.push_back('{7'h55, 2'd1, 16'd7,   1'b0, 3'd4, cfg[47:16]});
    exp_q.push_back('{7'h55, 2'd1, 16'd11,  1'b0, 3'd2, {16'h0, cfg[15:0]}});
    exp_q.push_back('{7'h55, 2'd1, 16'd137, 1'b0, 3'd1, 32'h0});
    exp_q.push_back('{7'h55, 2'd1, 16'd135, 1'b0, 3'd1, 32'h40});
    pulse_start(ch, cfg);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin tick(); n++; end
    chk({tag, "_timeout"}, busy, 0);
  endtask

  task automatic wait_obs(input string tag, input int cnt);
    int n = 0;
    while (obs_q.size() < rd_ptr + cnt && n < 500) begin tick(); n++; end
    chk({tag, "_obs_wait"}, obs_q.size() >= rd_ptr + cnt, 1);
  endtask

  // Compare the first n expected ops against what the DUT issued, drop the rest.
  task automatic check_ops(input string tag, input int n);
    op_t e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (rd_ptr < obs_q.size()) begin
        chk($sformatf("%s_op%0d", tag, i), obs_q[rd_ptr], e);
        rd_ptr++;
      end else chk($sformatf("%s_missing%0d", tag, i), obs_q.size(), rd_ptr + 1);
    end
    chk({tag, "_extra"}, obs_q.size() - rd_ptr, 0);
    rd_ptr = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    int d0, n;
    #12;
    chk("rst_out", {busy, done, fault, fault_code, o_step, o_old_cfg}, 0);
    chk("rst_fe", {fe_dev_addr, fe_reg_num_len, fe_reg_num, fe_read_len,
                   fe_read_strobe, fe_write_len, fe_write_strobe}, 0);
    chk("rst_tx", fe_tx_data, 0);
    @(negedge clk); resetn = 1'b1;
    tick(); tick();
    chk("post_rst_nostb", obs_q.size(), 0);

    // Nominal sequence
    d0 = done_cnt;
    run(8'h01, 48'h01C2BC011EB9);
    tick(); chk("t1_busy", busy, 1);
    wait_idle("t1");
    check_ops("t1", 8);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_old", o_old_cfg, 48'h01C2BC011EB8);
    chk("t1_fault", {fault, fault_code}, 0);
    chk("t1_step", o_step, 7);

    // Bus fault on op 3
    bus_op = 3; d0 = done_cnt;
    run(8'h01, 48'h01C2BC011EB9);
    wait_idle("t3");
    check_ops("t3", 4);
    chk("t3_fault", {fault, fault_code, o_step}, {1'b1, 2'd1, 4'd3});
    repeat (20) tick();
    chk("t3_nostb", obs_q.size() - rd_ptr, 0);
    chk("t3_sticky", {busy, fault}, 2'b01);
    chk("t3_nodone", done_cnt - d0, 0);

    // Both status bits on op 2: bus fault wins
    bus_op = 2; to_op = 2;
    run(8'h03, 48'h0);
    tick(); chk("t3b_clr", {fault, fault_code}, 0);
    wait_idle("t3b");
    check_ops("t3b", 3);
    chk("t3b_fault", {fault, fault_code, o_step}, {1'b1, 2'd1, 4'd2});

    // Timeout only on op 6
    bus_op = -1; to_op = 6;
    run(8'h04, 48'h123456789ABC);
    wait_idle("t3c");
    check_ops("t3c", 7);
    chk("t3c_fault", {fault, fault_code, o_step}, {1'b1, 2'd2, 4'd6});

    // Front-end hangs on op 1: watchdog
    to_op = -1; hang_op = 1;
    run(8'h05, 48'h0);
    wait_obs("t4", 2);
    n = 0;
    while (!fault && n < 200) begin tick(); n++; end
    chk("t4_cycles", n, 51);
    chk("t4_fault", {busy, fault, fault_code, o_step}, {1'b0, 1'b1, 2'd3, 4'd1});
    check_ops("t4", 2);
    hang_op = -1;
    tick(); tick();

    // Restart attempt mid-sequence is ignored
    si_regs = 48'hA1B2C3D4E5F6; d0 = done_cnt;
    run(8'h02, 48'h0A0B0C0D0E0F);
    wait_obs("t5", 5);
    pulse_start(8'hFF, 48'hFFFFFFFFFFFF);
    wait_idle("t5");
    check_ops("t5", 8);
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_old", o_old_cfg, 48'hA1B2C3D4E5F6);
    chk("t5_fault", fault, 0);
    repeat (10) tick();
    chk("t5_norestart", obs_q.size() - rd_ptr, 0);

    // Reset during WAIT of op 5
    si_regs = 48'h0F0E0D0C0B0A;
    run(8'h06, 48'h112233445566);
    wait_obs("t6", 6);
    tick();
    resetn = 1'b0; #1;
    chk("t6_rst_out", {busy, done, fault, fault_code, o_step, o_old_cfg}, 0);
    chk("t6_rst_fe", {fe_dev_addr, fe_reg_num_len, fe_reg_num, fe_read_len,
                      fe_read_strobe, fe_write_len, fe_write_strobe}, 0);
    chk("t6_rst_tx", fe_tx_data, 0);
    check_ops("t6a", 6);
    @(negedge clk); resetn = 1'b1;
    repeat (5) tick();
    chk("t6_nostb", obs_q.size() - rd_ptr, 0);
    d0 = done_cnt;
    run(8'h07, 48'h665544332211);
    wait_idle("t6b");
    check_ops("t6b", 8);
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_old", o_old_cfg, 48'h0F0E0D0C0B0A);
    chk("t6_fault", fault, 0);

    chk("monitor", mon_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
